cmos_frame_capture_ctrl: RTL
============================

Name: cmos_frame_capture_ctrl

Overview:
Sequences the CMOS capture datapath into a two-bank (ping-pong) frame buffer for the vision pipeline. It waits for sensor configuration and a settling period, then captures whole frames on request (single-shot) or continuously. It generates write strobes and addresses, and arbitrates bank ownership with the downstream consumer. It sits between the capture front-end (registered vsync/href/data) and the frame-buffer RAM/SDRAM write port.

Parameters:
H_PIXELS, 640, bytes per line expected
V_LINES, 480, lines per frame expected
ADDR_W, 19, write address width (must satisfy 2^ADDR_W >= H_PIXELS*V_LINES)
FRAME_WAITCNT, 10, frames discarded after cfg_done before capture is allowed

Ports:
cmos_pclk  in  1  pixel clock; sole clock
rst_n  in  1  async active-low reset
cfg_done  in  1  sensor I2C configuration complete (level)
cmos_frame_vsync  in  1  frame valid, high during active frame
cmos_frame_href  in  1  line valid (already vsync-qualified)
cmos_frame_data  in  8  pixel byte
cap_mode  in  1  0 = continuous, 1 = single-shot
cap_req  in  1  single-shot request pulse
rd_release  in  1  consumer frees bank rd_bank (pulse)
rd_bank  in  1  bank being released
wr_en  out  1  frame-buffer write strobe
wr_bank  out  1  bank being written
wr_addr  out  ADDR_W  write address within bank
wr_data  out  8  write data
bank_full  out  2  per-bank "frame ready" flags
frame_done  out  1  1-cycle pulse: good frame committed
frame_err  out  1  1-cycle pulse: frame size mismatch
drop_cnt  out  8  saturating count of frames dropped for lack of a free bank
busy  out  1  high in CAPTURE

Behaviour:
- Reset: all outputs 0; state IDLE; wr_bank=0; internal counters 0.
- Edges: vs_rise/vs_fall detected from a one-cycle-delayed copy of cmos_frame_vsync.
- IDLE: when cfg_done=1 -> SKIP. cfg_done deasserting in any state -> IDLE next cycle, with any in-progress frame abandoned; no bank is marked, and bank_full is kept.
- SKIP: count vs_fall; after FRAME_WAITCNT falls -> ARMED. A frame already active at entry is counted only by its fall.
- ARMED: single-shot mode requires a latched cap_req; the latch is set by the pulse in any state and cleared on entering CAPTURE. On vs_rise, if the request condition holds:
  - if bank wr_bank is free -> CAPTURE;
  - else if the other bank is free -> toggle wr_bank, then CAPTURE;
  - else stay ARMED, drop_cnt += 1 (saturates at 255), and keep the request latch.
  - A frame already active on arrival in ARMED is ignored; no mid-frame start.
- CAPTURE: each cycle with href=1: wr_en=1, wr_data=data, wr_addr=pix_cnt, pix_cnt += 1. Outputs are registered, so latency is 1 cycle from input. Once pix_cnt reaches H_PIXELS*V_LINES, further href bytes are not written (wr_en=0) and overflow is flagged.
- On vs_fall in CAPTURE -> DONE.
- DONE (1 cycle):
  - If pix_cnt==H_PIXELS*V_LINES and no overflow: set bank_full[wr_bank], pulse frame_done, toggle wr_bank.
  - Otherwise: pulse frame_err; the bank stays free and wr_bank is unchanged.
  - Clear pix_cnt and overflow. Next state: ARMED.
- rd_release clears bank_full[rd_bank] in any state. If it coincides with DONE setting the same bank, the set wins.
- vs_rise and vs_fall in the same cycle are impossible (single input). A cap_req arriving during CAPTURE latches for the next frame.
- busy=1 only in CAPTURE. In continuous mode cap_req is ignored.

Decomposition:
- Shared package cmos_cap_pkg: state encoding (IDLE, SKIP, ARMED, CAPTURE, DONE) and FRAME_PIXELS = H_PIXELS*V_LINES.
- One natural sub-module, cmos_bank_arbiter: bank_full flags, wr_bank selection, and release/commit priority.

Test Plan:
1. cfg_done=1, continuous, 4x2 frames (H=4, V=2, WAITCNT=2) -> first 2 frames produce no wr_en; frame 3 writes addr 0..7 on bank 0, then frame_done and bank_full=01; frame 4 goes to bank 1, bank_full=11.
2. Both banks full, frame 5 arrives -> no wr_en, drop_cnt=1; rd_release with rd_bank=0 -> frame 6 captured to bank 0.
3. Short frame (7 bytes) -> frame_err pulse, bank_full unchanged, next good frame reuses the same bank at addr 0.
4. Long frame (9 bytes) -> only addr 0..7 written, frame_err, no commit.
5. Single-shot: cap_req mid-frame -> capture starts at the next vs_rise; exactly one frame is committed; later frames are ignored until the next cap_req.
6. cfg_done dropped during CAPTURE -> state IDLE, wr_en stops next cycle, bank not marked; rst_n asserted mid-line -> all outputs 0 immediately.

Source files
------------

// File: rtl/cmos_cap_pkg.sv
// Shared types and helpers for the CMOS frame capture controller.
package cmos_cap_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSkip,
        StArmed,
        StCapture,
        StDone
    } cap_state_e;

    localparam int unsigned DEF_H_PIXELS     = 640;
    localparam int unsigned DEF_V_LINES      = 480;

    function automatic int unsigned frame_pixels(input int unsigned h, input int unsigned v);
        return h * v;
    endfunction

    localparam int unsigned DEF_FRAME_PIXELS = frame_pixels(DEF_H_PIXELS, DEF_V_LINES);

endpackage

// File: rtl/cmos_bank_arbiter.sv
// Ping-pong bank ownership: per-bank full flags and the bank currently being written.
module cmos_bank_arbiter (
    input  logic       cmos_pclk,
    input  logic       rst_n,
    input  logic       commit,
    input  logic       toggle,
    input  logic       rd_release,
    input  logic       rd_bank,
    output logic       wr_bank,
    output logic [1:0] bank_full
);

    logic       wr_bank_q, wr_bank_d;
    logic [1:0] full_q, full_d;

    always_comb begin
        full_d = full_q;
        // Release first so a commit to the same bank overrides it.
        if (rd_release) begin
            full_d[rd_bank] = 1'b0;
        end
        if (commit) begin
            full_d[wr_bank_q] = 1'b1;
        end
        wr_bank_d = wr_bank_q ^ (commit | toggle);
    end

    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
        end
    end

    assign wr_bank   = wr_bank_q;
    assign bank_full = full_q;

endmodule

// File: rtl/cmos_frame_capture_ctrl.sv
// Sequences whole-frame capture from the CMOS front-end into a two-bank frame buffer.
module cmos_frame_capture_ctrl
    import cmos_cap_pkg::*;
#(
    parameter int unsigned H_PIXELS      = DEF_H_PIXELS,
    parameter int unsigned V_LINES       = DEF_V_LINES,
    parameter int unsigned ADDR_W        = 19,
    parameter int unsigned FRAME_WAITCNT = 10
) (
    input  logic              cmos_pclk,
    input  logic              rst_n,
    input  logic              cfg_done,
    input  logic              cmos_frame_vsync,
    input  logic              cmos_frame_href,
    input  logic [7:0]        cmos_frame_data,
    input  logic              cap_mode,
    input  logic              cap_req,
    input  logic              rd_release,
    input  logic              rd_bank,
    output logic              wr_en,
    output logic              wr_bank,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic [1:0]        bank_full,
    output logic              frame_done,
    output logic              frame_err,
    output logic [7:0]        drop_cnt,
    output logic              busy
);

    localparam int unsigned     FRAME_PIX = frame_pixels(H_PIXELS, V_LINES);
    localparam logic [ADDR_W:0] FRAME_END = (ADDR_W + 1)'(FRAME_PIX);
    localparam int unsigned     SKIP_W    = $clog2(FRAME_WAITCNT + 1) + 1;
    localparam logic [SKIP_W-1:0] SKIP_LAST =
        (FRAME_WAITCNT == 0) ? '0 : SKIP_W'(FRAME_WAITCNT - 1);

    cap_state_e        state_q, state_d;
    logic              vsync_q;
    logic              vs_rise, vs_fall;
    logic [SKIP_W-1:0] skip_cnt_q;
    logic              req_q;
    logic [ADDR_W:0]   pix_cnt_q;
    logic              ovf_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;
    logic              frame_done_q, frame_err_q;
    logic [7:0]        drop_cnt_q;

    logic start_cap, bank_toggle, drop;
    logic cap_wr, cap_ovf, frame_good, in_done, commit;

    assign vs_rise = cmos_frame_vsync & ~vsync_q;
    assign vs_fall = ~cmos_frame_vsync & vsync_q;

    always_comb begin
        state_d     = state_q;
        start_cap   = 1'b0;
        bank_toggle = 1'b0;
        drop        = 1'b0;
        if (!cfg_done) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  state_d = StSkip;
                StSkip: begin
                    if (FRAME_WAITCNT == 0 || (vs_fall && skip_cnt_q == SKIP_LAST)) begin
                        state_d = StArmed;
                    end
                end
                StArmed: begin
                    // Only a rising vsync can start a frame; mid-frame arrival is ignored.
                    if (vs_rise && (!cap_mode || req_q)) begin
                        if (!bank_full[wr_bank]) begin
                            state_d   = StCapture;
                            start_cap = 1'b1;
                        end else if (!bank_full[~wr_bank]) begin
                            state_d     = StCapture;
                            start_cap   = 1'b1;
                            bank_toggle = 1'b1;
                        end else begin
                            drop = 1'b1;
                        end
                    end
                end
                StCapture: if (vs_fall) state_d = StDone;
                StDone:    state_d = StArmed;
                default:   state_d = StIdle;
            endcase
        end
    end

    assign cap_wr     = (state_q == StCapture) && cfg_done && cmos_frame_href &&
                        (pix_cnt_q != FRAME_END);
    assign cap_ovf    = (state_q == StCapture) && cfg_done && cmos_frame_href &&
                        (pix_cnt_q == FRAME_END);
    assign frame_good = (pix_cnt_q == FRAME_END) && !ovf_q;
    assign in_done    = (state_q == StDone) && cfg_done;
    assign commit     = in_done && frame_good;

    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            vsync_q      <= 1'b0;
            skip_cnt_q   <= '0;
            req_q        <= 1'b0;
            pix_cnt_q    <= '0;
            ovf_q        <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= 8'd0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
            drop_cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            vsync_q <= cmos_frame_vsync;

            if (state_q != StSkip) begin
                skip_cnt_q <= '0;
            end else if (vs_fall) begin
                skip_cnt_q <= skip_cnt_q + SKIP_W'(1);
            end

            // A request coinciding with capture start is kept for the following frame.
            if (cap_req && cap_mode) begin
                req_q <= 1'b1;
            end else if (start_cap) begin
                req_q <= 1'b0;
            end

            if (cap_wr) begin
                pix_cnt_q <= pix_cnt_q + (ADDR_W + 1)'(1);
            end else if (state_q != StCapture) begin
                pix_cnt_q <= '0;
            end

            if (cap_ovf) begin
                ovf_q <= 1'b1;
            end else if (state_q != StCapture) begin
                ovf_q <= 1'b0;
            end

            wr_en_q <= cap_wr;
            if (cap_wr) begin
                wr_addr_q <= pix_cnt_q[ADDR_W-1:0];
                wr_data_q <= cmos_frame_data;
            end

            frame_done_q <= commit;
            frame_err_q  <= in_done && !frame_good;

            if (drop && drop_cnt_q != 8'hFF) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

    cmos_bank_arbiter u_bank_arbiter (
        .cmos_pclk  (cmos_pclk),
        .rst_n      (rst_n),
        .commit     (commit),
        .toggle     (bank_toggle),
        .rd_release (rd_release),
        .rd_bank    (rd_bank),
        .wr_bank    (wr_bank),
        .bank_full  (bank_full)
    );

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;
    assign drop_cnt   = drop_cnt_q;
    assign busy       = (state_q == StCapture);

endmodule
